// File: rtl/tone_decoder.sv
// ============================================================================
// Module   : tone_decoder
// Brief    : Debounced, single-channel tone qualifier for the five band-pass
//            detector inputs; optional unacknowledged-hold timeout is enabled
//            with the TONE_TIMEOUT_EN macro.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tone_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_500_000,
  parameter int unsigned RELEASE_CYCLES  = 1_250_000,
  parameter int unsigned TIMEOUT_CYCLES  = 50_000_000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bp1,
  input  logic       bp2,
  input  logic       bp3,
  input  logic       bp4,
  input  logic       bp5,
  input  logic       tone_ack,
  output logic [2:0] tone_code,
  output logic       tone_valid,
  output logic [1:0] tone_state,
  output logic       tone_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] REL_C = CNT_W'(RELEASE_CYCLES);
`ifdef TONE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT_CYCLES);
`endif

  logic [4:0]       sync1_q;
  logic [4:0]       sync2_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       cand_q;
  logic [2:0]       code_q;
  logic             valid_q;
  logic             single;
  logic [2:0]       chan;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 5'd0;
      sync2_q <= 5'd0;
    end else begin
      sync1_q <= {bp5, bp4, bp3, bp2, bp1};
      sync2_q <= sync1_q;
    end
  end

  assign single = $onehot(sync2_q);

  always_comb begin
    chan = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (sync2_q[i]) chan = 3'(i + 1);
    end
  end

  // Saturating increment shared by every counting state.
  assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

`ifdef TONE_TIMEOUT_EN
  logic timeout_q;
  assign tone_timeout = timeout_q;
`else
  assign tone_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= 3'd0;
      code_q  <= 3'd0;
      valid_q <= 1'b0;
`ifdef TONE_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef TONE_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (single) begin
            cand_q <= chan;
            if (DEBOUNCE_CYCLES == 1) begin
              state_q <= ST_LOCKED;
              code_q  <= chan;
              valid_q <= 1'b1;
            end else begin
              state_q <= ST_QUALIFY;
              cnt_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_QUALIFY: begin
          if (single && chan == cand_q) begin
            if (cnt_d == DEB_C) begin
              state_q <= ST_LOCKED;
              code_q  <= cand_q;
              valid_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        end
        ST_LOCKED: begin
          // Ack has priority over a simultaneous timeout.
          if (tone_ack) begin
            state_q <= ST_RELEASE;
            code_q  <= 3'd0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
          end
`ifdef TONE_TIMEOUT_EN
          else if (cnt_d == TO_C) begin
            state_q   <= ST_RELEASE;
            code_q    <= 3'd0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
`endif
        end
        ST_RELEASE: begin
          if (sync2_q == 5'd0) begin
            if (cnt_d == REL_C) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end else begin
            cnt_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign tone_code  = code_q;
  assign tone_valid = valid_q;
  assign tone_state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_tone_decoder.sv
// ============================================================================
// Module   : tb_tone_decoder
// Brief    : Directed and randomized checks of tone_decoder against a
//            cycle-level behavioural model; define TONE_TIMEOUT_EN for both.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tone_decoder;

  localparam int DEB = 8;
  localparam int REL = 4;
  localparam int TO  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       bp1, bp2, bp3, bp4, bp5;
  logic       tone_ack;
  logic [2:0] tone_code;
  logic       tone_valid;
  logic [1:0] tone_state;
  logic       tone_timeout;

  int total = 0;
  int bad   = 0;

  tone_decoder #(
    .DEBOUNCE_CYCLES(DEB),
    .RELEASE_CYCLES (REL),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (26)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bp1         (bp1),
    .bp2         (bp2),
    .bp3         (bp3),
    .bp4         (bp4),
    .bp5         (bp5),
    .tone_ack    (tone_ack),
    .tone_code   (tone_code),
    .tone_valid  (tone_valid),
    .tone_state  (tone_state),
    .tone_timeout(tone_timeout)
  );

  always #5 clk = ~clk;

  // Reference model: raw inputs reach the decision logic two edges late;
  // phase 0 waiting, 1 debouncing, 2 holding a code, 3 waiting for quiet.
  logic [4:0] hist [2];
  int m_phase, m_run, m_cand;
  int e_code, e_valid, e_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic [4:0] raw, input logic ack, input logic r);
    logic [4:0] seen;
    int ones, ch;
    seen = hist[1];
    ones = $countones(seen);
    ch   = 0;
    for (int i = 0; i < 5; i++) if (seen[i]) ch = i + 1;
    e_to = 0;
    if (r) begin
      hist[0] = 5'd0; hist[1] = 5'd0;
      m_phase = 0; m_run = 0; m_cand = 0; e_code = 0; e_valid = 0;
      return;
    end
    hist[1] = hist[0];
    hist[0] = raw;
    if (m_phase == 0) begin
      m_run = 0;
      if (ones == 1) begin
        m_cand = ch; m_run = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (ones == 1 && ch == m_cand) m_run++;
      else begin m_phase = 0; m_run = 0; end
    end else if (m_phase == 2) begin
      if (ack) begin
        m_phase = 3; m_run = 0; e_code = 0; e_valid = 0;
      end else begin
        m_run++;
`ifdef TONE_TIMEOUT_EN
        if (m_run == TO) begin
          m_phase = 3; m_run = 0; e_code = 0; e_valid = 0; e_to = 1;
        end
`endif
      end
    end else begin
      m_run = (ones == 0) ? m_run + 1 : 0;
      if (m_run == REL) begin m_phase = 0; m_run = 0; end
    end
    if (m_phase == 1 && m_run == DEB) begin
      m_phase = 2; m_run = 0; e_code = m_cand; e_valid = 1;
    end
  endtask

  task automatic step(input logic [4:0] raw, input logic ack, input logic r);
    {bp5, bp4, bp3, bp2, bp1} = raw;
    tone_ack = ack;
    rst      = r;
    model(raw, ack, r);
    @(posedge clk);
    #1;
    check("code",    32'(tone_code),    32'(e_code));
    check("valid",   32'(tone_valid),   32'(e_valid));
    check("state",   32'(tone_state),   32'(m_phase));
    check("timeout", 32'(tone_timeout), 32'(e_to));
    @(negedge clk);
  endtask

  initial begin
    int vstep, rises, pulses;
    bit vseen, acked;
    logic prev_v;
    logic [4:0] pat;
    int seglen;

    hist[0] = 5'd0; hist[1] = 5'd0;
    m_phase = 0; m_run = 0; m_cand = 0; e_code = 0; e_valid = 0; e_to = 0;
    {bp5, bp4, bp3, bp2, bp1} = 5'd0;
    tone_ack = 1'b0;
    rst      = 1'b1;

    repeat (3) step(5'd0, 1'b1, 1'b1);
    check("rst_code",  32'(tone_code),  32'd0);
    check("rst_state", 32'(tone_state), 32'd0);

    // bp3 held, ack three cycles after valid
    vseen = 0; vstep = 0;
    for (int i = 1; i <= 20; i++) begin
      step(5'b00100, vseen && (i == vstep + 3), 1'b0);
      if (!vseen && tone_valid) begin vseen = 1; vstep = i; end
    end
    check("latency", 32'(vstep), 32'd10);
    repeat (8) step(5'd0, 1'b0, 1'b0);
    check("rearm1", 32'(tone_state), 32'd0);

    // short bp2 bursts never qualify
    repeat (2) begin
      repeat (5) step(5'b00010, 1'b0, 1'b0);
      repeat (4) step(5'd0, 1'b0, 1'b0);
      check("burst_idle", 32'(tone_state), 32'd0);
    end

    // ambiguous bp1+bp4
    repeat (30) step(5'b01001, 1'b1, 1'b0);
    check("multi_valid", 32'(tone_valid), 32'd0);

    // bp5 held long: one command only, then re-arm and second burst
    rises = 0; acked = 0; prev_v = 0;
    for (int i = 0; i < 40; i++) begin
      step(5'b10000, tone_valid && !acked, 1'b0);
      if (tone_valid && !prev_v) rises++;
      if (!tone_valid && prev_v) acked = 1;
      prev_v = tone_valid;
    end
    check("one_valid", 32'(rises), 32'd1);
    repeat (10) step(5'd0, 1'b0, 1'b0);
    vseen = 0;
    for (int i = 0; i < 12; i++) begin
      step(5'b10000, 1'b0, 1'b0);
      if (tone_valid) vseen = 1;
    end
    check("second_burst", 32'(vseen), 32'd1);
    step(5'd0, 1'b1, 1'b0);
    repeat (8) step(5'd0, 1'b0, 1'b0);

`ifdef TONE_TIMEOUT_EN
    // unacknowledged bp4 times out once
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step(5'b01000, 1'b0, 1'b0);
      if (tone_timeout) pulses++;
    end
    check("to_pulses", 32'(pulses), 32'd1);
    repeat (8) step(5'd0, 1'b0, 1'b0);
    // ack on the timeout cycle suppresses the pulse
    vseen = 0; vstep = 0; pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      step(5'b01000, vseen && (i == vstep + 20), 1'b0);
      if (tone_timeout) pulses++;
      if (!vseen && tone_valid) begin vseen = 1; vstep = i; end
    end
    check("to_ack_wins", 32'(pulses), 32'd0);
    repeat (8) step(5'd0, 1'b0, 1'b0);
`endif

    // reset while locked on bp2
    repeat (12) step(5'b00010, 1'b0, 1'b0);
    check("locked_code2", 32'(tone_code), 32'd2);
    step(5'b00010, 1'b1, 1'b1);
    check("rst_valid", 32'(tone_valid), 32'd0);
    step(5'b00010, 1'b0, 1'b0);
    repeat (6) step(5'd0, 1'b0, 1'b0);

    // randomized segments
    for (int s = 0; s < 250; s++) begin
      case ($urandom_range(0, 5))
        0:       pat = 5'd0;
        1:       pat = 5'($urandom_range(0, 31));
        default: pat = 5'(1 << $urandom_range(0, 4));
      endcase
      seglen = $urandom_range(1, 14);
      for (int k = 0; k < seglen; k++)
        step(pat, ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
